// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 4:1 mux select through its channels, holds each one
// for DWELL cycles, samples y at the end of each dwell and publishes the four
// samples as a frame with a one-cycle valid strobe. Single-shot or continuous.
// Optional build macro SCAN_MASK_EN adds chan_mask[3:0]: masked channels are
// skipped entirely and read back as 0 in the frame.
module mux_scan_ctrl #(
  parameter int unsigned DWELL = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       stop,
  input  logic       y,
`ifdef SCAN_MASK_EN
  input  logic [3:0] chan_mask,
`endif
  output logic [1:0] sel,
  output logic [3:0] frame,
  output logic       frame_valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST = 4'(DWELL - 1);

  state_t     state;
  logic [3:0] dwell_cnt;
  logic [3:0] shadow;
  logic [3:0] captured;
  logic [3:0] mask_q;
  logic [3:0] start_mask;
  logic       cont_q;
  logic       stop_q;
  logic [2:0] start_ch;
  logic [2:0] restart_ch;
  logic [2:0] next_ch;

`ifdef SCAN_MASK_EN
  assign start_mask = chan_mask;
`else
  assign start_mask = '0;
`endif

  // Lowest unmasked channel at or above 'from'; 4 means none is left.
  function automatic logic [2:0] first_unmasked(input logic [3:0] m,
                                                input logic [2:0] from);
    logic found;
    first_unmasked = 3'd4;
    found          = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!found && i >= 32'(from) && !m[i[1:0]]) begin
        first_unmasked = 3'(i);
        found          = 1'b1;
      end
    end
  endfunction

  // Shadow with the live sample merged in, plus channel-advance lookups.
  always_comb begin
    captured      = shadow;
    captured[sel] = y;
    start_ch      = first_unmasked(start_mask, 3'd0);
    restart_ch    = first_unmasked(mask_q, 3'd0);
    next_ch       = first_unmasked(mask_q, {1'b0, sel} + 3'd1);
  end

  // Scan sequencer with registered sel/frame/frame_valid/busy.
  // The last channel's sample goes straight from y into frame on the edge
  // that enters DONE, so no extra cycle is spent waiting for the shadow.
  // An all-masked scan spends one SCAN cycle before DONE so the strobe still
  // lands one cycle after the start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sel         <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
      dwell_cnt   <= '0;
      shadow      <= '0;
      cont_q      <= 1'b0;
      stop_q      <= 1'b0;
      mask_q      <= '0;
    end else begin
      frame_valid <= 1'b0;
      case (state)
        IDLE: begin
          sel <= '0;
          if (start) begin
            state     <= SCAN;
            busy      <= 1'b1;
            dwell_cnt <= '0;
            cont_q    <= cont;
            stop_q    <= 1'b0;
            mask_q    <= start_mask;
            sel       <= start_ch[2] ? 2'd0 : start_ch[1:0];
          end
        end
        SCAN: begin
          if (stop) stop_q <= 1'b1;
          if (&mask_q) begin
            state       <= DONE;
            frame       <= '0;
            frame_valid <= 1'b1;
          end else if (dwell_cnt == LAST) begin
            dwell_cnt <= '0;
            shadow    <= captured;
            if (next_ch[2]) begin
              state       <= DONE;
              frame       <= captured & ~mask_q;
              frame_valid <= 1'b1;
            end else begin
              sel <= next_ch[1:0];
            end
          end else begin
            dwell_cnt <= dwell_cnt + 4'd1;
          end
        end
        DONE: begin
          if (stop) stop_q <= 1'b1;
          dwell_cnt <= '0;
          if (cont_q && !stop_q && !stop) begin
            state <= SCAN;
            sel   <= restart_ch[2] ? 2'd0 : restart_ch[1:0];
          end else begin
            state <= IDLE;
            sel   <= '0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          sel   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: randomized bench for mux_scan_ctrl with DWELL=2 and a
// behavioural 4:1 mux closing the loop from sel back to y. Expected timing is
// computed from cycle offsets relative to the accepted start edge.
module tb_mux_scan_ctrl;

  localparam int unsigned DW = 2;
  localparam int FL = 4 * DW;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cont;
  logic       stop;
  logic [3:0] d;
  logic       y;
  logic [1:0] sel;
  logic [3:0] frame;
  logic       frame_valid;
  logic       busy;
  logic [3:0] chan_mask;
  logic [3:0] last_frame;
  int         checks = 0;
  int         fails  = 0;

  always #5 clk = ~clk;

  // The mux under control.
  assign y = d[sel];

  mux_scan_ctrl #(.DWELL(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cont       (cont),
    .stop       (stop),
    .y          (y),
`ifdef SCAN_MASK_EN
    .chan_mask  (chan_mask),
`endif
    .sel        (sel),
    .frame      (frame),
    .frame_valid(frame_valid),
    .busy       (busy)
  );

  // Start accepted at the next rising edge; returns at the falling edge just
  // after it (offset j=0). cont is scrambled afterwards, it must not matter.
  task automatic pulse_start(input logic c);
    @(negedge clk);
    start = 1'b1;
    cont  = c;
    @(negedge clk);
    start = 1'b0;
    cont  = 1'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (sel !== 2'd0) begin fails++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    checks++; if (frame !== 4'd0) begin fails++; $display("FAIL reset_frame got=%b exp=0000", frame); end
    checks++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL reset_fv got=%b exp=0", frame_valid); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy got=%b exp=0", busy); end
    checks++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL idle_fv got=%b exp=0", frame_valid); end
    last_frame = 4'd0;
  endtask

  // Single-shot scans; with poke set, extra start pulses land while busy.
  task automatic test_single_scan(input bit poke, input int n);
    logic [3:0] dv;
    int         sj;
    for (int it = 0; it < n; it++) begin
      dv = (it == 0 && !poke) ? 4'b1101 : 4'($urandom);
      sj = $urandom_range(0, FL);
      d  = dv;
      pulse_start(1'b0);
      for (int j = 0; j <= FL + 3; j++) begin
        if (j > 0) @(negedge clk);
        if (j == FL) last_frame = dv;
        if (j < FL) begin
          checks++;
          if (sel !== 2'(j / DW)) begin fails++; $display("FAIL single_sel j=%0d got=%0d exp=%0d", j, sel, j / DW); end
        end
        if (j > FL) begin
          checks++;
          if (sel !== 2'd0) begin fails++; $display("FAIL single_idle_sel j=%0d got=%0d exp=0", j, sel); end
        end
        checks++;
        if (frame_valid !== (j == FL)) begin fails++; $display("FAIL single_fv j=%0d got=%b exp=%b", j, frame_valid, j == FL); end
        checks++;
        if (busy !== (j <= FL)) begin fails++; $display("FAIL single_busy j=%0d got=%b exp=%b", j, busy, j <= FL); end
        checks++;
        if (frame !== last_frame) begin fails++; $display("FAIL single_frame j=%0d got=%b exp=%b", j, frame, last_frame); end
        start = poke && (j == sj);
      end
      start = 1'b0;
    end
  endtask

  task automatic test_start_while_busy();
    test_single_scan(1'b1, 5);
  endtask

  // Continuous scans of nf frames, stop pulse somewhere in the last frame
  // (including its DONE cycle); new data applied during each DONE cycle.
  task automatic test_continuous();
    logic [3:0] dfr [4];
    int nf, sj, tot, f, r, es;
    bit eb, ef, cs;
    for (int it = 0; it < 6; it++) begin
      nf = (it == 0) ? 2 : $urandom_range(1, 3);
      for (int k = 0; k < 4; k++) dfr[k] = 4'($urandom);
      if (it == 0) begin dfr[0] = 4'b1111; dfr[1] = 4'b0010; end
      sj  = (nf - 1) * (FL + 1) + ((it == 0) ? DW : $urandom_range(0, FL));
      tot = nf * (FL + 1) + 3;
      d   = dfr[0];
      pulse_start(1'b1);
      for (int j = 0; j < tot; j++) begin
        if (j > 0) @(negedge clk);
        f = j / (FL + 1);
        r = j % (FL + 1);
        if (f < nf) begin
          eb = 1'b1;
          ef = (r == FL);
          cs = (r < FL);
          es = r / DW;
          if (r == FL) last_frame = dfr[f];
        end else begin
          eb = 1'b0; ef = 1'b0; cs = 1'b1; es = 0;
        end
        if (cs) begin
          checks++;
          if (sel !== 2'(es)) begin fails++; $display("FAIL cont_sel j=%0d got=%0d exp=%0d", j, sel, es); end
        end
        checks++;
        if (frame_valid !== ef) begin fails++; $display("FAIL cont_fv j=%0d got=%b exp=%b", j, frame_valid, ef); end
        checks++;
        if (busy !== eb) begin fails++; $display("FAIL cont_busy j=%0d got=%b exp=%b", j, busy, eb); end
        checks++;
        if (frame !== last_frame) begin fails++; $display("FAIL cont_frame j=%0d got=%b exp=%b", j, frame, last_frame); end
        stop = (j == sj);
        if (f < nf && r == FL) d = dfr[f + 1];
      end
      stop = 1'b0;
    end
  endtask

  // Asynchronous reset between edges while sel=2, then a normal rescan.
  task automatic test_reset_mid_scan();
    d = 4'b1011;
    pulse_start(1'b0);
    repeat (2 * DW) @(negedge clk);
    checks++; if (sel !== 2'd2) begin fails++; $display("FAIL rstmid_pre_sel got=%0d exp=2", sel); end
    #2 rst = 1'b1;
    #1;
    checks++; if (sel !== 2'd0) begin fails++; $display("FAIL rstmid_sel got=%0d exp=0", sel); end
    checks++; if (frame !== 4'd0) begin fails++; $display("FAIL rstmid_frame got=%b exp=0000", frame); end
    checks++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL rstmid_fv got=%b exp=0", frame_valid); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    last_frame = 4'd0;
    @(negedge clk);
    rst = 1'b0;
    test_single_scan(1'b0, 2);
  endtask

`ifdef SCAN_MASK_EN
  task automatic test_chan_mask();
    logic [3:0] m, dv, ef;
    int ch[$];
    int dur;
    for (int it = 0; it < 8; it++) begin
      m  = (it == 0) ? 4'b0101 : (it == 1) ? 4'b1111 : 4'($urandom);
      dv = (it < 2) ? 4'b1111 : 4'($urandom);
      ch.delete();
      for (int i = 0; i < 4; i++) if (m[i] == 1'b0) ch.push_back(i);
      dur = (ch.size() == 0) ? 1 : ch.size() * DW;
      ef  = dv & ~m;
      d = dv;
      chan_mask = m;
      pulse_start(1'b0);
      for (int j = 0; j <= dur + 1; j++) begin
        if (j > 0) @(negedge clk);
        if (j == dur) last_frame = ef;
        if (j < dur && ch.size() > 0) begin
          checks++;
          if (sel !== 2'(ch[j / DW])) begin fails++; $display("FAIL mask_sel j=%0d got=%0d exp=%0d", j, sel, ch[j / DW]); end
        end
        checks++;
        if (frame_valid !== (j == dur)) begin fails++; $display("FAIL mask_fv j=%0d got=%b exp=%b", j, frame_valid, j == dur); end
        checks++;
        if (busy !== (j <= dur)) begin fails++; $display("FAIL mask_busy j=%0d got=%b exp=%b", j, busy, j <= dur); end
        checks++;
        if (frame !== last_frame) begin fails++; $display("FAIL mask_frame j=%0d got=%b exp=%b", j, frame, last_frame); end
      end
      chan_mask = 4'd0;
    end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; cont = 1'b0; stop = 1'b0;
    d = 4'd0; chan_mask = 4'd0; last_frame = 4'd0;
    test_reset();
    test_single_scan(1'b0, 6);
    test_start_while_busy();
    test_continuous();
    test_reset_mid_scan();
`ifdef SCAN_MASK_EN
    test_chan_mask();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequential controller that sits directly upstream of the 4:1 mux. It drives the mux select and consumes the mux output.
- Steps sel through channels 0..3 and holds each channel for DWELL cycles so the mux output settles.
- Samples y at the end of each dwell and assembles the four samples into a 4-bit frame.
- Presents the frame with a one-cycle valid strobe. Supports single-shot and continuous scanning.

Parameters:
- DWELL, 2, cycles each channel is held before sampling; legal range 1..15; dwell counter is 4 bits.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request a scan; sampled only in IDLE.
- cont  input  1  continuous-mode select; captured on the cycle start is accepted.
- stop  input  1  in continuous mode, end scanning after the current frame.
- y  input  1  mux output being scanned.
- sel  output  2  mux select, registered.
- frame  output  4  last completed frame; bit i = sample of channel i.
- frame_valid  output  1  one-cycle strobe, high when frame is updated.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high on rst.
- Reset values: sel=0, frame=0, frame_valid=0, busy=0, state=IDLE, dwell counter=0, shadow=0, cont_q=0, stop_q=0.
- Reset mid-scan aborts immediately to the reset values. No partial frame is published.
- States:
  - IDLE: sel=0; stays in IDLE until start=1.
  - SCAN: dwell_cnt counts 0..DWELL-1 on the current sel.
  - DONE: one cycle.
- IDLE -> SCAN on the edge where start=1.
  - At that edge: sel<=0, dwell_cnt<=0, cont_q<=cont, stop_q<=0.
- In SCAN, when dwell_cnt==DWELL-1:
  - Capture y into shadow[sel] and reset dwell_cnt.
  - If sel==3, go to DONE; otherwise sel<=sel+1.
  - Otherwise dwell_cnt increments.
- Entering DONE:
  - frame <= {y, shadow[2:0]}, i.e. the channel-3 sample comes from y at that edge.
  - frame_valid is high for exactly the DONE cycle.
- DONE exit:
  - If cont_q=1 and stop_q=0: go to SCAN, sel=0.
  - Otherwise: go to IDLE, sel=0.
- Latency: if start is accepted at edge k, frame_valid is high during the cycle that begins at edge k+4*DWELL.
  - In continuous mode, frames repeat every 4*DWELL+1 cycles.
- y for channel i is sampled at the last dwell edge while sel==i. The input d_i must be stable for the final dwell cycle.
- start while busy=1: ignored; it does not queue.
- stop:
  - Sticky; sets stop_q while in SCAN or DONE. Ignored in IDLE.
  - The current frame always completes and is published.
  - stop arriving in the DONE cycle itself still prevents the next frame.
- cont change mid-scan: no effect, because cont_q is frozen at start.
- frame holds its value between strobes and through IDLE. It is cleared only by reset.
- sel changes only on a dwell boundary or a state transition. It never glitches between registered values.

Optional Feature:
- Macro: SCAN_MASK_EN.
- Defined:
  - Adds input port chan_mask[3:0]. A mask bit of 1 skips that channel.
  - Skipped channels are never driven on sel and take no dwell cycles; their frame bit is 0.
  - Channel advance jumps to the next unmasked channel.
  - If chan_mask=4'b1111: start goes directly to DONE, with frame=0 and frame_valid one cycle after the start edge.
  - chan_mask is captured with start.
- Not defined: no chan_mask port; all four channels are scanned as above.

Test Plan:
- Bench instantiates the mux with sel/y wired to this block, DWELL=2.
- Single scan: d0=1, d1=0, d2=1, d3=1, cont=0, start pulse at edge k.
  - -> sel sequence 0,0,1,1,2,2,3,3; frame=4'b1101; frame_valid high only in the cycle from k+8; returns to IDLE with busy=0 at k+9.
- Continuous: cont=1, start; d=1,1,1,1 for frame 1, then d0..d3=0,1,0,0 changed during DONE.
  - -> frame 4'b1111, then 4'b0010; strobes 9 cycles apart.
- Stop: cont=1, start, stop pulse during sel=1 of frame 2.
  - -> frame 2 completes and is published; then IDLE; no frame 3.
- Reset mid-scan: assert rst asynchronously while sel=2, between clock edges.
  - -> sel, frame, frame_valid, busy go to 0 immediately, without waiting for a clock edge.
  - -> a new start scans normally from channel 0.
- Start while busy: start pulses during SCAN.
  - -> no restart and no extra frame; exactly one frame_valid per accepted start.
- SCAN_MASK_EN: chan_mask=4'b0101, d=1,1,1,1.
  - -> sel visits only 1 and 3; frame=4'b1010; strobe 4 cycles after start.
  - -> chan_mask=4'b1111 gives frame=0 with the strobe at k+1.
